branch_resolution_queue: RTL and testbench
==========================================

// Module: branch_resolution_queue
// PURPOSE
//  Update-side partner of the correlating predictor. Holds in-flight predictions in an in-order queue.
//  Matches each resolved branch outcome against the oldest entry.
//  Drives the predictor's training strobe (enable/branch_address/branch_result) one cycle after resolution.
//  Signals mispredict/flush to the fetch stage and keeps accuracy statistics.
// PARAMETERS
//  address_width  1   width of branch address; must match the predictor
//  depth_log2     2   queue depth = 2**depth_log2 entries (min 1)
//  count_width    16  width of statistics counters
// PORTS
//  clk           in   1              rising-edge clock
//  rst_n         in   1              asynchronous reset, active low
//  pred_valid    in   1              fetch issued a predicted branch this cycle
//  pred_ready    out  1              queue can accept (= !full)
//  pred_address  in   address_width  address of predicted branch
//  pred_taken    in   1              prediction value from predictor
//  res_valid     in   1              execute resolved the oldest outstanding branch
//  res_taken     in   1              actual outcome
//  upd_enable    out  1              one-cycle training strobe to predictor
//  upd_address   out  address_width  address of trained branch
//  upd_result    out  1              actual outcome to train with
//  mispredict    out  1              one-cycle pulse, same cycle as upd_enable, outcome != prediction
//  occupancy     out  depth_log2+1   entries currently held
//  res_underflow out  1              sticky: res_valid seen while queue empty
//  total_count   out  count_width    branches resolved, saturating
//  miss_count    out  count_width    mispredictions, saturating
// BEHAVIOUR
//  - Reset (rst_n=0, async): queue empty, read/write pointers 0.
//    All outputs 0 except pred_ready=1. Counters and sticky flag cleared.
//    Contents are discarded mid-operation.
//  - Storage: circular buffer of {address, predicted}. Pointers are depth_log2 bits wide and wrap modulo depth.
//    occupancy is 0..depth; full when occupancy==depth.
//  - Push: pred_valid & pred_ready writes the entry at the write pointer and advances it.
//    pred_valid while full is ignored (no overwrite, occupancy unchanged).
//  - Resolve: res_valid & occupancy!=0 pops the head.
//    Next cycle: upd_enable=1, upd_address=head.address, upd_result=res_taken,
//    mispredict=(res_taken!=head.predicted). Latency is exactly 1 cycle.
//    Strobes last one cycle; upd_address/upd_result hold their value until the next resolve.
//  - Empty resolve: res_valid with occupancy==0 produces no update and no counter change.
//    res_underflow is set and held until reset.
//  - Mispredict flush: at the resolving edge, all younger entries are discarded.
//    Pointers reset to 0 and occupancy becomes 0.
//    A push in the same cycle is dropped (wrong path).
//  - Simultaneous push + correct resolve: both happen and occupancy is unchanged.
//    Legal when full only if pred_ready was 1. pred_ready depends only on registered occupancy, so there is no bypass.
//  - Counters: total_count += 1 per resolve and miss_count += 1 per mispredict.
//    Both stick at 2**count_width-1.
//  - All state registers are updated only on the posedge of clk or on the async reset. No latches.
// TESTING
//  1 Reset: drive rst_n=0 mid-stream with 3 entries queued
//    -> occupancy=0, pred_ready=1, counters=0 immediately, with no clk edge.
//  2 Fill: 4 pushes (addr 0,1,0,1; taken 1,0,1,1) at depth 4
//    -> occupancy=4, pred_ready=0. A 5th push is ignored.
//  3 Correct resolves: 4 resolves with res_taken 1,0,1,1
//    -> 4 upd_enable pulses, each 1 cycle after res_valid.
//    Addresses 0,1,0,1; mispredict never set; total_count=4, miss_count=0.
//  4 Mispredict flush: queue 3 entries (pred 1,1,1), resolve with res_taken=0 while also pushing
//    -> mispredict=1, upd_result=0, occupancy=0 next cycle, push dropped, miss_count=1.
//  5 Wrap: 10 interleaved push/resolve pairs at depth 4
//    -> update addresses follow push order across pointer wrap; occupancy is steady.
//  6 Underflow/saturation: res_valid on empty queue
//    -> res_underflow=1 and no upd_enable.
//    With count_width=2, 5 mispredicts -> miss_count=3.

Source files
------------

// File: rtl/branch_resolution_queue_if.sv
// Bundles the prediction-issue, resolution, training and statistics signals of the branch resolution queue.
// Latency: none (wiring only).
// Backpressure: pred_ready is the only backpressure signal; resolution has no ready.
// Ports: the slave side (queue) takes pred_* and res_* and drives pred_ready, upd_*,
// mispredict, occupancy, res_underflow and the counters. The master side is the mirror image.
interface branch_resolution_queue_if #(
    parameter int address_width = 1,
    parameter int depth_log2    = 2,
    parameter int count_width   = 16
) ();
    logic                     pred_valid;
    logic                     pred_ready;
    logic [address_width-1:0] pred_address;
    logic                     pred_taken;
    logic                     res_valid;
    logic                     res_taken;
    logic                     upd_enable;
    logic [address_width-1:0] upd_address;
    logic                     upd_result;
    logic                     mispredict;
    logic [depth_log2:0]      occupancy;
    logic                     res_underflow;
    logic [count_width-1:0]   total_count;
    logic [count_width-1:0]   miss_count;

    modport slave (
        input  pred_valid, pred_address, pred_taken, res_valid, res_taken,
        output pred_ready, upd_enable, upd_address, upd_result, mispredict,
               occupancy, res_underflow, total_count, miss_count
    );

    modport master (
        output pred_valid, pred_address, pred_taken, res_valid, res_taken,
        input  pred_ready, upd_enable, upd_address, upd_result, mispredict,
               occupancy, res_underflow, total_count, miss_count
    );
endinterface

// File: rtl/branch_resolution_queue.sv
// In-order queue of in-flight predictions. It matches each resolved outcome against the oldest entry and trains the predictor.
// Latency: the training strobe and the mispredict pulse appear 1 cycle after res_valid.
// Backpressure: pred_ready = !full, taken from registered occupancy; a push while full is ignored; a resolve on an empty queue only sets res_underflow.
// Ports: clk, rst_n (async, active low); bq (slave modport) carries pred_* in, pred_ready out,
// res_* in, upd_* / mispredict training outputs, occupancy, sticky res_underflow and the saturating counters.
module branch_resolution_queue #(
    parameter int address_width = 1,
    parameter int depth_log2    = 2,
    parameter int count_width   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    branch_resolution_queue_if.slave bq
);
    localparam int DEPTH = 1 << depth_log2;
    localparam logic [depth_log2:0]    FULL_OCC = {1'b1, {depth_log2{1'b0}}};
    localparam logic [count_width-1:0] CNT_MAX  = {count_width{1'b1}};

    typedef struct packed {
        logic [address_width-1:0] address;
        logic                     predicted;
    } entry_t;

    entry_t                   mem [DEPTH];
    logic [depth_log2-1:0]    wr_ptr;
    logic [depth_log2-1:0]    rd_ptr;
    logic [depth_log2:0]      occ;
    entry_t                   head;
    logic                     push;
    logic                     pop;
    logic                     miss;

    logic                     upd_enable_r;
    logic [address_width-1:0] upd_address_r;
    logic                     upd_result_r;
    logic                     mispredict_r;
    logic                     underflow_r;
    logic [count_width-1:0]   total_r;
    logic [count_width-1:0]   miss_r;

    assign head          = mem[rd_ptr];
    assign bq.pred_ready = (occ != FULL_OCC);
    assign push          = bq.pred_valid & bq.pred_ready;
    assign pop           = bq.res_valid & (occ != '0);
    assign miss          = pop & (bq.res_taken != head.predicted);

    // The payload storage needs no reset because the pointers and occupancy define which entries are valid.
    // A push that coincides with a mispredict is on the wrong path, so it is not written.
    always_ff @(posedge clk) begin
        if (push && !miss) begin
            mem[wr_ptr] <= '{address: bq.pred_address, predicted: bq.pred_taken};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (miss) begin
            // Every younger entry is on the wrong path, so the whole queue is flushed.
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                occ <= occ + 1'b1;
            end else if (pop && !push) begin
                occ <= occ - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_enable_r  <= 1'b0;
            upd_address_r <= '0;
            upd_result_r  <= 1'b0;
            mispredict_r  <= 1'b0;
            underflow_r   <= 1'b0;
            total_r       <= '0;
            miss_r        <= '0;
        end else begin
            upd_enable_r <= pop;
            mispredict_r <= miss;
            // The address and result hold until the next resolve, so the predictor can sample them late.
            if (pop) begin
                upd_address_r <= head.address;
                upd_result_r  <= bq.res_taken;
            end
            if (bq.res_valid && occ == '0) underflow_r <= 1'b1;
            if (pop && total_r != CNT_MAX) total_r <= total_r + 1'b1;
            if (miss && miss_r != CNT_MAX) miss_r  <= miss_r + 1'b1;
        end
    end

    assign bq.upd_enable    = upd_enable_r;
    assign bq.upd_address   = upd_address_r;
    assign bq.upd_result    = upd_result_r;
    assign bq.mispredict    = mispredict_r;
    assign bq.occupancy     = occ;
    assign bq.res_underflow = underflow_r;
    assign bq.total_count   = total_r;
    assign bq.miss_count    = miss_r;
endmodule

// File: tb/tb_branch_resolution_queue.sv
module tb_branch_resolution_queue;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    // Each expected training update is packed as {address, result, mispredict}.
    logic [2:0] sb [$];

    branch_resolution_queue_if #(.address_width(1), .depth_log2(2), .count_width(16)) bi ();
    branch_resolution_queue_if #(.address_width(1), .depth_log2(2), .count_width(2))  bi2 ();

    branch_resolution_queue #(.address_width(1), .depth_log2(2), .count_width(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bq    (bi)
    );

    branch_resolution_queue #(.address_width(1), .depth_log2(2), .count_width(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bq    (bi2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every training strobe from the main queue is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bi.upd_enable) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL upd_spurious: got addr=%0b res=%0b mis=%0b expected no update at %0t",
                         bi.upd_address, bi.upd_result, bi.mispredict, $time);
            end else begin
                logic [2:0] e;
                e = sb.pop_front();
                if ({bi.upd_address, bi.upd_result, bi.mispredict} !== e) begin
                    n_fail++;
                    $display("FAIL upd: got addr=%0b res=%0b mis=%0b expected addr=%0b res=%0b mis=%0b at %0t",
                             bi.upd_address, bi.upd_result, bi.mispredict, e[2], e[1], e[0], $time);
                end
            end
        end
    end

    task automatic expect_upd(input logic a, input logic r, input logic m);
        sb.push_back({a, r, m});
    endtask

    // Inputs are driven 1 time unit after a posedge. The task returns 1 time unit after the next posedge, when the state from that edge is visible.
    task automatic cyc(input logic pv, input logic pa, input logic pt, input logic rv, input logic rt);
        bi.pred_valid = pv; bi.pred_address = pa; bi.pred_taken = pt;
        bi.res_valid = rv;  bi.res_taken = rt;
        @(posedge clk);
        #1;
        bi.pred_valid = 1'b0; bi.res_valid = 1'b0;
    endtask

    task automatic cyc2(input logic pv, input logic pt, input logic rv, input logic rt);
        bi2.pred_valid = pv; bi2.pred_address = 1'b0; bi2.pred_taken = pt;
        bi2.res_valid = rv;  bi2.res_taken = rt;
        @(posedge clk);
        #1;
        bi2.pred_valid = 1'b0; bi2.res_valid = 1'b0;
    endtask

    initial begin
        logic [1:0] m [$];
        logic [1:0] hd;
        logic [3:0] kk;
        logic       pa;
        logic       pt;
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bi.pred_valid = 0;  bi.pred_address = 0;  bi.pred_taken = 0;  bi.res_valid = 0;  bi.res_taken = 0;
        bi2.pred_valid = 0; bi2.pred_address = 0; bi2.pred_taken = 0; bi2.res_valid = 0; bi2.res_taken = 0;
        #12;
        chk("rst_occ", bi.occupancy, 0);
        chk("rst_ready", bi.pred_ready, 1);
        chk("rst_upd_en", bi.upd_enable, 0);
        chk("rst_underflow", bi.res_underflow, 0);
        chk("rst_total", bi.total_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Test 1: an asynchronous reset with entries queued clears the queue immediately.
        cyc(1, 1, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("t1_full_occ", bi.occupancy, 4);
        expect_upd(1, 1, 0);
        cyc(0, 0, 0, 1, 1);
        chk("t1_occ3", bi.occupancy, 3);
        cyc(0, 0, 0, 0, 0);
        chk("t1_total1", bi.total_count, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_occ", bi.occupancy, 0);
        chk("t1_async_ready", bi.pred_ready, 1);
        chk("t1_async_total", bi.total_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Test 2: fill to depth 4. A fifth push is ignored.
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        chk("t2_occ", bi.occupancy, 4);
        chk("t2_ready", bi.pred_ready, 0);
        cyc(1, 0, 0, 0, 0);
        chk("t2_occ_after_5th", bi.occupancy, 4);

        // Test 3: four correct resolves. An overwritten head would show up as a mispredict.
        expect_upd(0, 1, 0); cyc(0, 0, 0, 1, 1);
        chk("t3_en0", bi.upd_enable, 1); chk("t3_mis0", bi.mispredict, 0);
        expect_upd(1, 0, 0); cyc(0, 0, 0, 1, 0);
        chk("t3_en1", bi.upd_enable, 1); chk("t3_mis1", bi.mispredict, 0);
        expect_upd(0, 1, 0); cyc(0, 0, 0, 1, 1);
        chk("t3_en2", bi.upd_enable, 1); chk("t3_mis2", bi.mispredict, 0);
        expect_upd(1, 1, 0); cyc(0, 0, 0, 1, 1);
        chk("t3_en3", bi.upd_enable, 1); chk("t3_mis3", bi.mispredict, 0);
        chk("t3_occ", bi.occupancy, 0);
        chk("t3_total", bi.total_count, 4);
        chk("t3_miss", bi.miss_count, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t3_strobe_off", bi.upd_enable, 0);
        chk("t3_addr_hold", bi.upd_address, 1);

        // Test 4: a mispredict flushes the queue and drops a simultaneous push.
        cyc(1, 1, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        expect_upd(1, 0, 1);
        cyc(1, 0, 0, 1, 0);
        chk("t4_mis", bi.mispredict, 1);
        chk("t4_result", bi.upd_result, 0);
        chk("t4_occ", bi.occupancy, 0);
        chk("t4_miss", bi.miss_count, 1);
        cyc(0, 0, 0, 0, 0);
        chk("t4_occ_dropped", bi.occupancy, 0);
        chk("t4_mis_pulse", bi.mispredict, 0);
        cyc(1, 0, 1, 0, 0);
        expect_upd(0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        chk("t4_total", bi.total_count, 6);

        // Test 5: push/resolve pairs at steady occupancy 2, running through several pointer wraps.
        m.delete();
        m.push_back(2'b11); cyc(1, 1, 1, 0, 0);
        m.push_back(2'b00); cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            kk = 4'(k);
            pa = kk[1];
            pt = (k % 3 == 0);
            hd = m.pop_front();
            expect_upd(hd[1], hd[0], 0);
            m.push_back({pa, pt});
            cyc(1, pa, pt, 1, hd[0]);
            chk("t5_occ", bi.occupancy, 2);
        end
        for (int k = 0; k < 2; k++) begin
            hd = m.pop_front();
            expect_upd(hd[1], hd[0], 0);
            cyc(0, 0, 0, 1, hd[0]);
        end
        chk("t5_occ_drained", bi.occupancy, 0);
        chk("t5_total", bi.total_count, 18);
        chk("t5_miss", bi.miss_count, 1);

        // Test 6: a resolve on an empty queue, then counter saturation with a 2-bit counter.
        cyc(0, 0, 0, 1, 1);
        chk("t6_underflow", bi.res_underflow, 1);
        chk("t6_no_upd", bi.upd_enable, 0);
        chk("t6_total_same", bi.total_count, 18);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t6_underflow_sticky", bi.res_underflow, 1);

        for (int i = 1; i <= 5; i++) begin
            cyc2(1, 1, 0, 0);
            cyc2(0, 0, 1, 0);
            chk("t6_sat_miss", bi2.miss_count, (i < 3) ? i : 3);
            chk("t6_sat_total", bi2.total_count, (i < 3) ? i : 3);
        end

        cyc(0, 0, 0, 0, 0);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
